fw_status_regbank: RTL and testbench

//  Parametrised AXI4-Lite slave register bank: next generation of the firmware status block.

---
 rtl/fw_status_regbank.sv | 230 +++++++++++++++++++++++
 tb/tb_fw_status_regbank.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_status_regbank.sv
// AXI4-Lite firmware status register bank: version, uptime, sticky events with
// masked interrupt, fabric control words and sampled fabric status words.
module fw_status_regbank #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 8,
  parameter int          N_CTRL             = 4,
  parameter int          N_STAT             = 4,
  parameter logic [31:0] FW_VERSION         = 32'h0000_0100,
  parameter logic [31:0] CTRL_RESET         = 32'h0
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [N_CTRL*32-1:0]                   ctrl_o,
  input  logic [((N_STAT > 0) ? N_STAT : 1)*32-1:0] status_i,
  input  logic [31:0]                            event_i,
  output logic                                   irq_o
);

  localparam int unsigned DW        = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW        = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned IW        = AW - 2;
  localparam int unsigned NC        = N_CTRL;
  localparam int unsigned NS        = N_STAT;
  localparam int unsigned NS_ARR    = (N_STAT > 0) ? N_STAT : 1;
  localparam int unsigned CTRL_BASE = 4;
  localparam int unsigned STAT_BASE = CTRL_BASE + NC;
  localparam int unsigned MAP_END   = STAT_BASE + NS;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DW-1:0] uptime;
  logic [DW-1:0] sticky;
  logic [DW-1:0] mask;
  logic [DW-1:0] stat_q [NS_ARR];

  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          wr_en;
  logic          rd_en;
  logic          wr_mapped;
  logic [DW-1:0] wmask;
  logic [DW-1:0] sticky_clr;
  logic [DW-1:0] rd_word;
  logic          rd_err;

  // Protection bits and byte-lane address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_idx    = s00_axi_awaddr[AW-1:2];
  assign rd_idx    = s00_axi_araddr[AW-1:2];
  assign wr_en     = s00_axi_awready & s00_axi_awvalid & s00_axi_wready & s00_axi_wvalid;
  assign rd_en     = s00_axi_arready & s00_axi_arvalid;
  assign wr_mapped = (32'(wr_idx) < MAP_END);

  // Expand byte strobes into a bit mask and derive the write-1-to-clear vector.
  always_comb begin
    wmask      = '0;
    sticky_clr = '0;
    for (int unsigned b = 0; b < DW / 8; b++) begin
      wmask[8*b +: 8] = {8{s00_axi_wstrb[b]}};
    end
    if (wr_en && (wr_idx == IW'(2))) begin
      sticky_clr = s00_axi_wdata & wmask;
    end
  end

  // Write address/data acceptance and write response channel.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= RESP_OKAY;
    end else begin
      if (!s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid) begin
        s00_axi_awready <= 1'b1;
        s00_axi_wready  <= 1'b1;
      end else begin
        s00_axi_awready <= 1'b0;
        s00_axi_wready  <= 1'b0;
      end
      if (wr_en) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // Control words with per-byte write strobes.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int unsigned k = 0; k < NC; k++) begin
        ctrl_o[k*32 +: 32] <= CTRL_RESET;
      end
    end else if (wr_en) begin
      for (int unsigned k = 0; k < NC; k++) begin
        if (32'(wr_idx) == CTRL_BASE + k) begin
          for (int unsigned b = 0; b < DW / 8; b++) begin
            if (s00_axi_wstrb[b]) begin
              ctrl_o[k*32 + 8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // Interrupt mask with per-byte write strobes.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      mask <= '0;
    end else if (wr_en && (wr_idx == IW'(3))) begin
      mask <= (mask & ~wmask) | (s00_axi_wdata & wmask);
    end
  end

  // Sticky event flags; a new event outranks a same-cycle clear.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~sticky_clr) | event_i;
    end
  end

  // Level interrupt from any unmasked sticky flag.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |(sticky & mask);
    end
  end

  // Free-running uptime counter, wraps naturally.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      uptime <= '0;
    end else begin
      uptime <= uptime + DW'(1);
    end
  end

  // Fabric status words registered one cycle.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int unsigned k = 0; k < NS_ARR; k++) begin
        stat_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NS_ARR; k++) begin
        stat_q[k] <= status_i[k*32 +: 32];
      end
    end
  end

  // Read decode; unmapped offsets return zero with an error flag.
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      IW'(0):  rd_word = FW_VERSION;
      IW'(1):  rd_word = uptime;
      IW'(2):  rd_word = sticky;
      IW'(3):  rd_word = mask;
      default: begin
        rd_err = 1'b1;
        for (int unsigned k = 0; k < NC; k++) begin
          if (32'(rd_idx) == CTRL_BASE + k) begin
            rd_word = ctrl_o[k*32 +: 32];
            rd_err  = 1'b0;
          end
        end
        for (int unsigned k = 0; k < NS; k++) begin
          if (32'(rd_idx) == STAT_BASE + k) begin
            rd_word = stat_q[k];
            rd_err  = 1'b0;
          end
        end
      end
    endcase
  end

  // Read address acceptance and read data channel.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= RESP_OKAY;
    end else begin
      if (!s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid) begin
        s00_axi_arready <= 1'b1;
      end else begin
        s00_axi_arready <= 1'b0;
      end
      if (rd_en) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_word;
        s00_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s00_axi_rvalid && s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fw_status_regbank.sv
// Randomized self-checking bench for fw_status_regbank against a register-map model.
module tb_fw_status_regbank;

  localparam logic [31:0] VER = 32'h0000_0100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] ctrl_o;
  logic [127:0] status_i;
  logic [31:0]  event_i;
  logic         irq_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] ctrl_m [4];
  logic [31:0] stat_m [4];
  logic [31:0] sticky_m, mask_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fw_status_regbank dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready), .ctrl_o(ctrl_o), .status_i(status_i),
    .event_i(event_i), .irq_o(irq_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] smask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) ctrl_m[k] = 32'h0;
    sticky_m = 32'h0;
    mask_m   = 32'h0;
  endfunction

  // Register-map semantics of one committed write, plus any event arriving with it.
  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb, input logic [31:0] ev);
    int w;
    logic [31:0] m;
    logic [1:0] resp;
    w = int'(addr) / 4;
    m = smask(strb);
    resp = 2'b00;
    if (w == 2) sticky_m = sticky_m & ~(data & m);
    else if (w == 3) mask_m = (mask_m & ~m) | (data & m);
    else if (w >= 4 && w < 8) ctrl_m[w-4] = (ctrl_m[w-4] & ~m) | (data & m);
    else if (w >= 12) resp = 2'b10;
    sticky_m = sticky_m | ev;
    return resp;
  endfunction

  function automatic void model_read(input logic [7:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int w;
    w = int'(addr) / 4;
    resp = 2'b00;
    data = 32'h0;
    if (w == 0) data = VER;
    else if (w == 2) data = sticky_m;
    else if (w == 3) data = mask_m;
    else if (w >= 4 && w < 8) data = ctrl_m[w-4];
    else if (w >= 8 && w < 12) data = stat_m[w-8];
    else if (w >= 12) resp = 2'b10;
  endfunction

  function automatic logic [127:0] ctrl_exp();
    return {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]};
  endfunction

  task automatic wait_sig(input int which, input string tag);
    int n = 0;
    logic s;
    s = (which == 0) ? awready : (which == 1) ? bvalid : (which == 2) ? arready : rvalid;
    while (!s && n < 20) begin
      @(posedge clk); #1;
      n++;
      s = (which == 0) ? awready : (which == 1) ? bvalid : (which == 2) ? arready : rvalid;
    end
    if (!s) check(tag, 0, 1);
  endtask

  // Full write transaction; ev is driven on event_i during the commit cycle.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [31:0] ev, output logic [1:0] resp);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    wait_sig(0, "aw_timeout");
    event_i = ev;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; event_i = 32'h0;
    wait_sig(1, "b_timeout");
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int at);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    wait_sig(2, "ar_timeout");
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_sig(3, "r_timeout");
    data = rdata; resp = rresp; at = cyc;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic pulse_event(input logic [31:0] ev);
    event_i = ev;
    @(posedge clk); #1;
    event_i = 32'h0;
    sticky_m = sticky_m | ev;
    @(posedge clk); #1;
  endtask

  task automatic set_status();
    for (int k = 0; k < 4; k++) begin
      stat_m[k] = $urandom;
      status_i[k*32 +: 32] = stat_m[k];
    end
  endtask

  logic [31:0] d, d2, exp_d, old;
  logic [1:0]  r, r2, exp_r;
  int          t1, t2;
  logic        flag;

  initial begin
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0; status_i = '0; event_i = '0;
    model_reset();
    for (int k = 0; k < 4; k++) stat_m[k] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_resp", {bresp, rresp}, 4'b0000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ctrl", ctrl_o, 128'h0);
    check("rst_irq", irq_o, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Version and uptime progression.
    axi_read(8'h00, d, r, t1);
    check("version", d, VER);
    check("version_resp", r, 2'b00);
    axi_read(8'h04, d, r, t1);
    repeat (10) @(posedge clk);
    #1;
    axi_read(8'h04, d2, r2, t2);
    check("uptime_delta", d2 - d, 32'(t2 - t1));

    // Control words and byte strobes.
    for (int k = 0; k < 4; k++) begin
      axi_write(8'(16 + 4*k), 32'(k + 1), 4'hF, 32'h0, r);
      void'(model_write(8'(16 + 4*k), 32'(k + 1), 4'hF, 32'h0));
    end
    for (int k = 0; k < 4; k++) begin
      axi_read(8'(16 + 4*k), d, r, t1);
      check("ctrl_rb", d, 32'(k + 1));
    end
    check("ctrl_o_1234", ctrl_o, ctrl_exp());
    axi_write(8'h10, 32'hAABB_CCDD, 4'b0010, 32'h0, r);
    void'(model_write(8'h10, 32'hAABB_CCDD, 4'b0010, 32'h0));
    axi_read(8'h10, d, r, t1);
    check("ctrl_strb", d, 32'h0000_CC01);

    // Sticky flags, mask and interrupt.
    axi_write(8'h0C, 32'h4, 4'hF, 32'h0, r);
    void'(model_write(8'h0C, 32'h4, 4'hF, 32'h0));
    pulse_event(32'h5);
    axi_read(8'h08, d, r, t1);
    check("sticky_set", d, 32'h5);
    check("irq_set", irq_o, 1'b1);
    axi_write(8'h08, 32'h4, 4'hF, 32'h0, r);
    void'(model_write(8'h08, 32'h4, 4'hF, 32'h0));
    check("irq_clr", irq_o, 1'b0);
    axi_read(8'h08, d, r, t1);
    check("sticky_w1c", d, 32'h1);
    axi_write(8'h08, 32'h1, 4'hF, 32'h1, r);
    void'(model_write(8'h08, 32'h1, 4'hF, 32'h1));
    axi_read(8'h08, d, r, t1);
    check("set_beats_clr", d, 32'h1);

    // Unmapped access.
    axi_write(8'hFC, 32'hFFFF_FFFF, 4'hF, 32'h0, r);
    check("unmapped_bresp", r, 2'b10);
    axi_read(8'hFC, d, r, t1);
    check("unmapped_rdata", d, 32'h0);
    check("unmapped_rresp", r, 2'b10);
    check("unmapped_noeffect", ctrl_o, ctrl_exp());

    // Same-edge read and write of one register returns the old value.
    old = ctrl_m[0];
    fork
      axi_write(8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, r);
      axi_read(8'h10, d, r2, t1);
    join
    void'(model_write(8'h10, 32'hDEAD_BEEF, 4'hF, 32'h0));
    check("rw_same_old", d, old);
    check("rw_same_ctrl", ctrl_o, ctrl_exp());

    // AW ahead of W, held response stalls writes but not reads.
    awaddr = 8'h10; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    flag = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (awready) flag = 1'b1;
    end
    check("aw_waits_w", flag, 1'b0);
    wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
    wait_sig(0, "aw_timeout");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    void'(model_write(8'h10, 32'h1111_2222, 4'hF, 32'h0));
    awaddr = 8'h14; wdata = 32'h3333_4444; awvalid = 1'b1; wvalid = 1'b1;
    flag = 1'b0;
    fork
      begin
        repeat (5) begin
          @(posedge clk); #1;
          if (!bvalid || awready) flag = 1'b1;
        end
      end
      axi_read(8'h10, d, r2, t1);
    join
    check("bvalid_stall", flag, 1'b0);
    check("stall_bresp", bresp, 2'b00);
    check("conc_read", d, 32'h1111_2222);
    bready = 1'b1;
    wait_sig(0, "aw2_timeout");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    void'(model_write(8'h14, 32'h3333_4444, 4'hF, 32'h0));
    wait_sig(1, "b2_timeout");
    @(posedge clk); #1;
    bready = 1'b0;
    check("single_writes", ctrl_o, ctrl_exp());

    // Randomized traffic against the model.
    for (int it = 0; it < 80; it++) begin
      int op, w;
      logic [7:0]  a;
      logic [31:0] dat, ev;
      logic [3:0]  st;
      set_status();
      op = $urandom_range(0, 2);
      w = $urandom_range(0, 16);
      if (w == 16) w = 63;
      a = 8'(w * 4);
      if (op == 0) begin
        dat = $urandom;
        st  = 4'($urandom_range(0, 15));
        ev  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
        axi_write(a, dat, st, ev, r);
        exp_r = model_write(a, dat, st, ev);
        check("rnd_bresp", r, exp_r);
        check("rnd_ctrl_o", ctrl_o, ctrl_exp());
        check("rnd_irq_w", irq_o, |(sticky_m & mask_m));
      end else if (op == 1) begin
        axi_read(a, d, r, t1);
        model_read(a, exp_d, exp_r);
        if (w != 1) check("rnd_rdata", d, exp_d);
        check("rnd_rresp", r, exp_r);
      end else begin
        ev = 32'($urandom) & 32'($urandom);
        pulse_event(ev);
        check("rnd_irq_ev", irq_o, |(sticky_m & mask_m));
      end
    end

    // Reset while a read response is being held.
    axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, r);
    void'(model_write(8'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0));
    pulse_event(32'h1);
    check("pre_rst_irq", irq_o, 1'b1);
    araddr = 8'h10; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    wait_sig(2, "ar_rst_timeout");
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_sig(3, "r_rst_timeout");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rvalid_drop", rvalid, 1'b0);
    check("rst_rdata_clr", rdata, 32'h0);
    check("rst_ctrl_clr", ctrl_o, 128'h0);
    check("rst_irq_clr", irq_o, 1'b0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    flag = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rvalid || bvalid) flag = 1'b1;
    end
    check("no_resp_after_rst", flag, 1'b0);
    axi_read(8'h08, d, r, t1);
    check("rst_sticky", d, 32'h0);
    axi_read(8'h0C, d, r, t1);
    check("rst_mask", d, 32'h0);
    axi_read(8'h1C, d, r, t1);
    check("rst_ctrl3", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
